// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: FIFO state encoding and default widths.
package wb_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } wb_state_t;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;

endpackage

// File: rtl/wb_entry_reg.sv
// One write-back FIFO entry: a loadable address/data register pair, cleared on reset.
module wb_entry_reg
    import wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] next_add,
    input  logic [DATA_W-1:0] next_data,
    output logic [ADDR_W-1:0] add,
    output logic [DATA_W-1:0] data
);

    logic [ADDR_W-1:0] add_reg;
    logic [DATA_W-1:0] data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_reg  <= '0;
            data_reg <= '0;
        end else if (load) begin
            add_reg  <= next_add;
            data_reg <= next_data;
        end
    end

    assign add  = add_reg;
    assign data = data_reg;

endmodule

// File: rtl/write_back_stage.sv
// Write-back stage: 2-entry result FIFO feeding the register file and the RAW forwarding unit.
// Optional feature: define WB_COMMIT_COUNT_EN to add the 16-bit oCommitCount output.
module write_back_stage
    import wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iValid,
    output logic              oReady,
    input  logic              iWriteEnable,
    input  logic [ADDR_W-1:0] iResult_Add,
    input  logic [DATA_W-1:0] iResult_Data,
    output logic              oResult_Valid,
    output logic [ADDR_W-1:0] oResult_Add,
    output logic [DATA_W-1:0] oResult_Data,
    output logic              oRF_WE,
    output logic [ADDR_W-1:0] oRF_Add,
    output logic [DATA_W-1:0] oRF_Data,
    input  logic              iRF_Ack
`ifdef WB_COMMIT_COUNT_EN
    ,
    output logic [15:0]       oCommitCount
`endif
);

    wb_state_t state_reg, state_next;

    // Slot 0 always holds the oldest entry; slot 1 is used only in FULL.
    logic [ADDR_W-1:0] entry_add       [2];
    logic [DATA_W-1:0] entry_data      [2];
    logic [ADDR_W-1:0] entry_next_add  [2];
    logic [DATA_W-1:0] entry_next_data [2];
    logic              entry_load      [2];

    logic store;
    logic pop;
    logic not_empty;
    logic newest_idx;

    assign not_empty = (state_reg != EMPTY);
    assign oReady    = (state_reg != FULL);
    assign store     = iValid && oReady && iWriteEnable;
    assign pop       = not_empty && iRF_Ack;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_reg <= EMPTY;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next         = state_reg;
        entry_load[0]      = 1'b0;
        entry_load[1]      = 1'b0;
        entry_next_add[0]  = iResult_Add;
        entry_next_data[0] = iResult_Data;
        entry_next_add[1]  = iResult_Add;
        entry_next_data[1] = iResult_Data;
        case (state_reg)
            EMPTY: begin
                if (store) begin
                    entry_load[0] = 1'b1;
                    state_next    = ONE;
                end
            end
            ONE: begin
                if (store && pop) begin
                    entry_load[0] = 1'b1;
                end else if (store) begin
                    entry_load[1] = 1'b1;
                    state_next    = FULL;
                end else if (pop) begin
                    state_next    = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    entry_load[0]      = 1'b1;
                    entry_next_add[0]  = entry_add[1];
                    entry_next_data[0] = entry_data[1];
                    state_next         = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            wb_entry_reg #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W)
            ) u_entry (
                .clk       (Clock),
                .rst       (Reset),
                .load      (entry_load[gi]),
                .next_add  (entry_next_add[gi]),
                .next_data (entry_next_data[gi]),
                .add       (entry_add[gi]),
                .data      (entry_data[gi])
            );
        end
    endgenerate

    assign newest_idx    = (state_reg == FULL);
    assign oRF_WE        = not_empty;
    assign oResult_Valid = not_empty;
    assign oRF_Add       = not_empty ? entry_add[0]  : '0;
    assign oRF_Data      = not_empty ? entry_data[0] : '0;
    assign oResult_Add   = not_empty ? entry_add[newest_idx]  : '0;
    assign oResult_Data  = not_empty ? entry_data[newest_idx] : '0;

`ifdef WB_COMMIT_COUNT_EN
    logic [15:0] commit_count_reg;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)    commit_count_reg <= '0;
        else if (pop) commit_count_reg <= commit_count_reg + 16'd1;
    end

    assign oCommitCount = commit_count_reg;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Directed plus randomized bench for write_back_stage with a queue scoreboard of pending entries.
module tb_write_back_stage;

    logic        Clock;
    logic        Reset;
    logic        iValid;
    logic        oReady;
    logic        iWriteEnable;
    logic [7:0]  iResult_Add;
    logic [15:0] iResult_Data;
    logic        oResult_Valid;
    logic [7:0]  oResult_Add;
    logic [15:0] oResult_Data;
    logic        oRF_WE;
    logic [7:0]  oRF_Add;
    logic [15:0] oRF_Data;
    logic        iRF_Ack;
`ifdef WB_COMMIT_COUNT_EN
    logic [15:0] oCommitCount;
    int unsigned exp_count;
`endif

    int n_checks;
    int n_fail;
    logic [23:0] sb_q[$];   // {add, data}, oldest at front

    write_back_stage dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iValid        (iValid),
        .oReady        (oReady),
        .iWriteEnable  (iWriteEnable),
        .iResult_Add   (iResult_Add),
        .iResult_Data  (iResult_Data),
        .oResult_Valid (oResult_Valid),
        .oResult_Add   (oResult_Add),
        .oResult_Data  (oResult_Data),
        .oRF_WE        (oRF_WE),
        .oRF_Add       (oRF_Add),
        .oRF_Data      (oRF_Data),
        .iRF_Ack       (iRF_Ack)
`ifdef WB_COMMIT_COUNT_EN
        ,
        .oCommitCount  (oCommitCount)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check outputs against the model, then advance the model across the edge.
    task automatic cycle(input logic v, input logic we, input logic [7:0] a,
                         input logic [15:0] d, input logic ack);
        logic accept;
        logic do_pop;
        iValid       = v;
        iWriteEnable = we;
        iResult_Add  = a;
        iResult_Data = d;
        iRF_Ack      = ack;
        #1;
        chk("ready", {31'd0, oReady}, {31'd0, sb_q.size() != 2});
        chk("rf_we", {31'd0, oRF_WE}, {31'd0, sb_q.size() != 0});
        chk("res_valid", {31'd0, oResult_Valid}, {31'd0, sb_q.size() != 0});
        if (sb_q.size() != 0) begin
            chk("rf_add", {24'd0, oRF_Add}, {24'd0, sb_q[0][23:16]});
            chk("rf_data", {16'd0, oRF_Data}, {16'd0, sb_q[0][15:0]});
            chk("res_add", {24'd0, oResult_Add}, {24'd0, sb_q[$][23:16]});
            chk("res_data", {16'd0, oResult_Data}, {16'd0, sb_q[$][15:0]});
        end
`ifdef WB_COMMIT_COUNT_EN
        chk("commit_count", {16'd0, oCommitCount}, exp_count);
`endif
        accept = v && (sb_q.size() != 2);
        do_pop = ack && (sb_q.size() != 0);
        if (do_pop) begin
            $display("commit add=%h data=%h", sb_q[0][23:16], sb_q[0][15:0]);
            void'(sb_q.pop_front());
`ifdef WB_COMMIT_COUNT_EN
            exp_count = (exp_count + 1) & 32'hFFFF;
`endif
        end
        if (accept && we) sb_q.push_back({a, d});
        @(posedge Clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
`ifdef WB_COMMIT_COUNT_EN
        exp_count = 0;
`endif
        Reset        = 1'b1;
        iValid       = 1'b0;
        iWriteEnable = 1'b0;
        iResult_Add  = '0;
        iResult_Data = '0;
        iRF_Ack      = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        chk("reset_rf_we", {31'd0, oRF_WE}, 32'd0);
        chk("reset_res_valid", {31'd0, oResult_Valid}, 32'd0);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        chk("post_reset_ready", {31'd0, oReady}, 32'd1);

        // Single write with ack held high
        cycle(1, 1, 8'h05, 16'h1234, 1);
        chk("single_rf_we", {31'd0, oRF_WE}, 32'd1);
        chk("single_res", {8'd0, oResult_Add, oResult_Data}, 32'h00051234);
        cycle(0, 1, 8'h00, 16'h0000, 1);
        chk("single_empty", {31'd0, oRF_WE}, 32'd0);

        // Fill and stall, same address pair
        cycle(1, 1, 8'h03, 16'hAAAA, 0);
        cycle(1, 1, 8'h03, 16'hBBBB, 0);
        chk("full_ready", {31'd0, oReady}, 32'd0);
        chk("full_res_data", {16'd0, oResult_Data}, 32'h0000BBBB);
        chk("full_rf_data", {16'd0, oRF_Data}, 32'h0000AAAA);
        cycle(1, 1, 8'h99, 16'h9999, 0);   // refused while FULL
        cycle(0, 0, 8'h00, 16'h0000, 1);   // commits AAAA
        chk("pair_second_rf", {16'd0, oRF_Data}, 32'h0000BBBB);
        cycle(0, 0, 8'h00, 16'h0000, 1);   // commits BBBB

        // Simultaneous store and pop in ONE
        cycle(1, 1, 8'h11, 16'h0011, 0);
        cycle(1, 1, 8'h07, 16'h0042, 1);
        chk("simul_ready", {31'd0, oReady}, 32'd1);
        chk("simul_rf", {8'd0, oRF_Add, oRF_Data}, 32'h00070042);
        chk("simul_res", {8'd0, oResult_Add, oResult_Data}, 32'h00070042);
        cycle(0, 0, 8'h00, 16'h0000, 1);

        // Dropped write: from EMPTY, and in ONE
        cycle(1, 0, 8'h22, 16'h2222, 0);
        chk("drop_empty_we", {31'd0, oRF_WE}, 32'd0);
        cycle(1, 1, 8'h33, 16'h3333, 0);
        cycle(1, 0, 8'h44, 16'h4444, 0);
        chk("drop_one_ready", {31'd0, oReady}, 32'd1);
        chk("drop_one_rf", {8'd0, oRF_Add, oRF_Data}, 32'h00333333);
        cycle(0, 0, 8'h00, 16'h0000, 1);

        // Randomized mix
        for (int i = 0; i < 200; i++) begin
            cycle($urandom_range(0, 1), $urandom_range(0, 3) != 0,
                  8'($urandom), 16'($urandom), $urandom_range(0, 1));
        end
        repeat (3) cycle(0, 0, 8'h00, 16'h0000, 1);

        // Reset asserted in FULL while ack is high
        cycle(1, 1, 8'h55, 16'h5555, 0);
        cycle(1, 1, 8'h66, 16'h6666, 0);
        iRF_Ack = 1'b1;
        iValid  = 1'b0;
        #1;
        Reset = 1'b1;
        #1;
        chk("rst_rf_we", {31'd0, oRF_WE}, 32'd0);
        chk("rst_res_valid", {31'd0, oResult_Valid}, 32'd0);
        chk("rst_rf", {8'd0, oRF_Add, oRF_Data}, 32'd0);
        chk("rst_res", {8'd0, oResult_Add, oResult_Data}, 32'd0);
`ifdef WB_COMMIT_COUNT_EN
        chk("rst_commit_count", {16'd0, oCommitCount}, 32'd0);
        exp_count = 0;
`endif
        sb_q.delete();
        @(posedge Clock);
        #2;
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        chk("rst_release_ready", {31'd0, oReady}, 32'd1);
        cycle(1, 1, 8'h77, 16'h7777, 1);
        cycle(0, 0, 8'h00, 16'h0000, 1);
        cycle(0, 0, 8'h00, 16'h0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
